// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - 16-bit stereo I2S transmitter with a single-entry sample holding register
// Optional: define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.

module i2s_tx (
    input  logic        master_clk,
    input  logic        rst,
    input  logic        sample_clk_en,
    input  logic        bit_clk_en,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
`ifdef I2S_TX_UNDERRUN_CNT_EN
    output logic [15:0] underrun_cnt,
`endif
    output logic        underrun
);

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  slot;
    logic [4:0]  slot_nxt;
    logic [4:0]  bit_idx;
    logic [2:0]  bclk_cnt;
    logic        bclk_armed;

    logic [31:0] hold_word;
    logic        hold_full;
    logic [31:0] shift_reg;
    logic        ready_en;

    logic        frame_strobe;
    logic        slot_strobe;
    logic        load;
    logic        accept;

    // A frame boundary only counts when the frame strobe lands on a bit strobe.
    assign frame_strobe = sample_clk_en && bit_clk_en;
    assign slot_strobe  = (state == ST_RUN) && bit_clk_en;
    assign load         = (state == ST_RUN) && frame_strobe;

    // Any aligned frame strobe (expected or not) restarts the frame at slot 0.
    assign slot_nxt = frame_strobe ? 5'd0 : slot + 5'd1;

    // Slot n carries word bit (32-n); slot 0 wraps to bit 0 of the word being retired.
    assign bit_idx = 5'd0 - slot_nxt;

    // The load cycle never accepts, so a sample offered then waits for the next frame.
    assign in_ready = ready_en && !hold_full && !load;
    assign accept   = in_valid && in_ready;

    // State register.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: wait in SYNC for the first aligned frame strobe, then run forever.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SYNC: if (frame_strobe) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_SYNC;
        endcase
    end

    // Slot counter and serial outputs; bclk falls with each new slot and rises 8 cycles later.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            slot       <= 5'd0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            bclk_cnt   <= 3'd0;
            bclk_armed <= 1'b0;
        end else if (slot_strobe) begin
            slot       <= slot_nxt;
            bclk       <= 1'b0;
            bclk_cnt   <= 3'd0;
            bclk_armed <= 1'b1;
            lrclk      <= slot_nxt[4];
            sdata      <= shift_reg[bit_idx];
        end else if (bclk_armed && !bclk) begin
            if (bclk_cnt == 3'd7) begin
                bclk <= 1'b1;
            end else begin
                bclk_cnt <= bclk_cnt + 3'd1;
            end
        end
    end

    // Holding register fill and hand-off to the shift register at each frame start.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            hold_word <= 32'd0;
            hold_full <= 1'b0;
            shift_reg <= 32'd0;
        end else if (load) begin
            shift_reg <= hold_full ? hold_word : 32'd0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_word <= {left_in, right_in};
            hold_full <= 1'b1;
        end
    end

    // Underrun pulse when a frame starts with nothing held.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            underrun <= 1'b0;
        end else begin
            underrun <= load && !hold_full;
        end
    end

    // Keeps in_ready low during reset and lets it rise on the first cycle afterwards.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= 16'd0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized self-checking bench for i2s_tx against a frame-level model

module tb_i2s_tx;

    logic        master_clk;
    logic        rst;
    logic        sample_clk_en;
    logic        bit_clk_en;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic        in_valid;
    logic        in_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    i2s_tx dut (
        .master_clk    (master_clk),
        .rst           (rst),
        .sample_clk_en (sample_clk_en),
        .bit_clk_en    (bit_clk_en),
        .left_in       (left_in),
        .right_in      (right_in),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
`ifdef I2S_TX_UNDERRUN_CNT_EN
        .underrun_cnt  (underrun_cnt),
`endif
        .underrun      (underrun)
    );

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Frame-level reference model
    bit          m_run;
    bit          m_alive;
    int          m_slot;
    logic [31:0] m_q[$];
    logic [31:0] m_cur;
    logic [31:0] m_prev;
    bit          exp_bclk;
    bit          bclk_armed;
    int          bclk_k;
    bit          exp_under;
    bit          exp_sd;
    bit          exp_lr;
    int          m_ucnt;

    logic [31:0] obs_acc;
    logic [31:0] hist[$];
    int          under_seen;
    int          rdy_seen;
    int          src_mode;
    int          cyc;

    task automatic model_reset();
        m_run      = 0;
        m_alive    = 0;
        m_q.delete();
        m_cur      = 32'd0;
        m_prev     = 32'd0;
        m_slot     = 0;
        exp_bclk   = 0;
        bclk_armed = 0;
        bclk_k     = 0;
        exp_under  = 0;
        exp_sd     = 0;
        exp_lr     = 0;
        m_ucnt     = 0;
        hist.delete();
        obs_acc    = 32'd0;
    endtask

    function automatic logic [31:0] hist_at(input int idx);
        if (idx < hist.size()) return hist[idx];
        return 32'hxxxxxxxx;
    endfunction

    // One master_clk cycle: drive strobes, check in_ready, advance model, check outputs.
    task automatic tick(input bit se, input bit be);
        bit exp_rdy;
        bit hs;
        bit slot_evt;
        sample_clk_en = se;
        bit_clk_en    = be;
        #1;
        exp_rdy = m_alive && rst && (m_q.size() == 0) && !(m_run && se && be);
        check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (in_ready) rdy_seen++;
        hs = in_valid && exp_rdy;
        @(posedge master_clk);
        exp_under = 0;
        slot_evt  = 0;
        if (!rst) begin
            model_reset();
        end else begin
            m_alive = 1;
            if (!m_run) begin
                if (se && be) m_run = 1;
            end else begin
                if (bclk_armed && !exp_bclk) begin
                    bclk_k++;
                    if (bclk_k == 8) exp_bclk = 1;
                end
                if (be) begin
                    slot_evt = 1;
                    if (se) begin
                        m_slot = 0;
                        m_prev = m_cur;
                        if (m_q.size() == 0) begin
                            m_cur     = 32'd0;
                            exp_under = 1;
                            if (m_ucnt < 65535) m_ucnt++;
                        end else begin
                            m_cur = m_q.pop_front();
                        end
                    end else begin
                        m_slot = (m_slot + 1) % 32;
                    end
                    exp_lr     = (m_slot >= 16);
                    exp_sd     = (m_slot == 0) ? m_prev[0] : m_cur[32 - m_slot];
                    exp_bclk   = 0;
                    bclk_armed = 1;
                    bclk_k     = 0;
                end
            end
            if (hs) m_q.push_back({left_in, right_in});
        end
        @(negedge master_clk);
        check_eq("sdata",    {31'd0, sdata},    {31'd0, exp_sd});
        check_eq("lrclk",    {31'd0, lrclk},    {31'd0, exp_lr});
        check_eq("bclk",     {31'd0, bclk},     {31'd0, exp_bclk});
        check_eq("underrun", {31'd0, underrun}, {31'd0, exp_under});
        if (underrun) under_seen++;
        if (slot_evt) begin
            if (m_slot == 0) begin
                obs_acc[0] = sdata;
                hist.push_back(obs_acc);
                obs_acc = 32'd0;
            end else begin
                obs_acc[32 - m_slot] = sdata;
            end
        end
        if (hs) begin
            {left_in, right_in} = $urandom;
            if (src_mode != 1) in_valid = 0;
        end
        if (src_mode == 2 && !in_valid) in_valid = ($urandom_range(0, 3) == 0);
        if (src_mode == 0) in_valid = 0;
    endtask

    task automatic step();
        tick((cyc % 512) == 0, (cyc % 16) == 0);
        cyc++;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          h0;
        int          found;
        logic [31:0] d_word;

        rst           = 1'b0;
        sample_clk_en = 1'b0;
        bit_clk_en    = 1'b0;
        left_in       = 16'd0;
        right_in      = 16'd0;
        in_valid      = 1'b0;
        src_mode      = 0;
        cyc           = 0;
        under_seen    = 0;
        rdy_seen      = 0;
        model_reset();

        // Reset state
        repeat (3) tick(1'b1, 1'b1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check_eq("ucnt_reset", {16'd0, underrun_cnt}, 32'd0);
`endif

        // Directed sample before the first frame
        rst      = 1'b1;
        cyc      = 500;
        left_in  = 16'hA5A5;
        right_in = 16'h0F0F;
        in_valid = 1'b1;
        src_mode = 3;
        repeat (1040) step();
        check_eq("sync_frame", hist_at(0), 32'h0);
        check_eq("a5_frame",   hist_at(1), 32'hA5A50F0F);

        // Starvation: one underrun per frame
        src_mode = 0;
        in_valid = 1'b0;
        while ((cyc % 512) != 0) step();
        under_seen = 0;
        repeat (1536) step();
        check_eq("underrun_per_frame", under_seen, 3);

        // Continuous valid: one in_ready pulse per frame
        src_mode = 1;
        {left_in, right_in} = $urandom;
        in_valid = 1'b1;
        while ((cyc % 512) != 0) step();
        rdy_seen = 0;
        repeat (2048) step();
        check_eq("ready_pulses", rdy_seen, 4);

        // Transfer offered in the load cycle goes to the following frame
        src_mode = 0;
        in_valid = 1'b0;
        while ((cyc % 512) != 0) step();
        repeat (512) step();
        d_word   = $urandom;
        {left_in, right_in} = d_word;
        in_valid = 1'b1;
        src_mode = 3;
        h0 = hist.size() + 1;
        repeat (1026) step();
        check_eq("collide_empty", hist_at(h0),     32'h0);
        check_eq("collide_next",  hist_at(h0 + 1), d_word);

        // Random traffic, stray frame strobe, mid-frame restart
        src_mode = 2;
        repeat (700) step();
        while ((cyc % 16) != 5) step();
        tick(1'b1, 1'b0);
        cyc++;
        repeat (300) step();
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step();
            if (m_slot == 10 && (cyc % 16) == 1) found = 1;
        end
        check_eq("reach_slot10", found, 1);
        cyc = 0;
        repeat (1600) step();

`ifdef I2S_TX_UNDERRUN_CNT_EN
        src_mode = 0;
        in_valid = 1'b0;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_eq("ucnt_mid", {16'd0, underrun_cnt}, m_ucnt);
        src_mode = 2;
`endif

        // Asynchronous reset at slot 20
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            step();
            if (m_slot == 20 && (cyc % 16) == 1) found = 1;
        end
        check_eq("reach_slot20", found, 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_sdata",    {31'd0, sdata},    32'd0);
        check_eq("rst_lrclk",    {31'd0, lrclk},    32'd0);
        check_eq("rst_bclk",     {31'd0, bclk},     32'd0);
        check_eq("rst_underrun", {31'd0, underrun}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check_eq("rst_ucnt", {16'd0, underrun_cnt}, 32'd0);
`endif
        model_reset();
        src_mode = 0;
        in_valid = 1'b0;
        repeat (4) tick(1'b0, 1'b0);
        rst      = 1'b1;
        cyc      = 300;
        src_mode = 2;
        repeat (1800) step();
        check_eq("post_rst_sync_frame", hist_at(0), 32'h0);

`ifdef I2S_TX_UNDERRUN_CNT_EN
        // Saturation under forced strobes
        src_mode = 0;
        in_valid = 1'b0;
        repeat (70000) tick(1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        check_eq("ucnt_sat",   {16'd0, underrun_cnt}, 32'h0000FFFF);
        check_eq("ucnt_model", {16'd0, underrun_cnt}, m_ucnt);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have port master_clk  input  1  24.576 MHz system clock; all state clocked on its rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-003 SHALL have port sample_clk_en  input  1  48 kHz frame-strobe pulse, one master_clk wide, every 512 cycles.
REQ-004 SHALL have port bit_clk_en  input  1  1.536 MHz bit-strobe pulse, one master_clk wide, every 16 cycles; coincident with sample_clk_en when sample_clk_en is high.
REQ-005 SHALL have port left_in  input  16  left sample, two's complement.
REQ-006 SHALL have port right_in  input  16  right sample, two's complement.
REQ-007 SHALL have port in_valid  input  1  left_in/right_in pair valid.
REQ-008 SHALL have port in_ready  output  1  holding register empty; transfer occurs when in_valid && in_ready.
REQ-009 SHALL have port bclk  output  1  I2S bit clock.
REQ-010 SHALL have port lrclk  output  1  I2S word select; 0 = left.
REQ-011 SHALL have port sdata  output  1  I2S serial data, MSB first.
REQ-012 SHALL have port underrun  output  1  one-cycle pulse when a frame starts with no sample held.

Function
REQ-013 SHALL implement a two-state FSM: SYNC (after reset) and RUN.
REQ-014 SYNC SHALL hold bclk=0, lrclk=0, sdata=0, and move to RUN on the first cycle with sample_clk_en && bit_clk_en.
REQ-015 In RUN, a 5-bit slot counter SHALL be set to 0 on each cycle with sample_clk_en && bit_clk_en, and otherwise incremented modulo 32 on each bit_clk_en.
REQ-016 On each bit_clk_en in RUN, bclk, lrclk and sdata SHALL all update on the same edge: bclk goes to 0 and the new slot values are driven, visible one cycle after the strobe.
REQ-017 bclk SHALL return to 1 exactly 8 master_clk cycles after falling, giving a 50% duty cycle.
REQ-018 lrclk SHALL be 0 for slots 0-15 and 1 for slots 16-31.
REQ-019 The frame word SHALL be {left,right} (32 bits).
REQ-020 sdata in slot n (1..31) SHALL be frame-word bit (32-n); slot 0 SHALL carry bit 0 of the previous frame word (standard one-bclk I2S delay).
REQ-021 A single 32-bit holding register SHALL be provided; in_ready SHALL be 1 whenever it is empty.
REQ-022 At slot 0, the holding register SHALL move to the shift register and become empty.
REQ-023 If the holding register is empty at slot 0, the frame word SHALL be 0 and underrun SHALL pulse for one cycle.
REQ-024 An accepted transfer coinciding with a slot-0 load SHALL be taken by the next frame, not the current one; in_ready SHALL be 0 in that cycle.
REQ-025 A sample_clk_en without a coincident bit_clk_en SHALL be ignored.
REQ-026 A sample_clk_en arriving at any slot other than the expected slot 0 SHALL restart the frame at slot 0; no error flag is raised.

Reset
REQ-027 While rst=0, the block SHALL hold state=SYNC, slot=0, bclk=0, lrclk=0, sdata=0, in_ready=0, underrun=0, holding register empty, shift register 0.
REQ-028 in_ready SHALL rise on the first cycle after rst deasserts.
REQ-029 Reset asserted mid-frame SHALL take effect immediately (asynchronously) and discard any partial frame.

Configuration
REQ-030 Macro I2S_TX_UNDERRUN_CNT_EN defined: the block SHALL add output underrun_cnt (16 bits), a counter that resets to 0, increments on each underrun pulse, and saturates at 16'hFFFF.
REQ-031 Macro I2S_TX_UNDERRUN_CNT_EN undefined: the port and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset release, left=16'hA5A5, right=16'h0F0F presented before the first frame -> at frame 2, slots 1-16 on sdata read A5A5 MSB-first and slots 17-31 plus the next slot 0 read 0F0F; lrclk toggles at slot 16.
REQ-033 No in_valid after reset -> first RUN frame has sdata all 0 and underrun pulses exactly once per frame.
REQ-034 in_valid held high continuously -> in_ready pulses once per 512 cycles, and no sample is lost or duplicated across 4 frames.
REQ-035 Transfer offered in the same cycle as the slot-0 load -> that sample appears in the following frame.
REQ-036 rst asserted at slot 20 -> all outputs reach 0 the same cycle; after release, output resumes cleanly from the next aligned strobe.
REQ-037 With I2S_TX_UNDERRUN_CNT_EN defined, 70000 starved frames (forced strobes) -> underrun_cnt = 16'hFFFF.
